// File: rtl/pcie_avst2mfb_pkg.sv
// Shared width helpers and the protocol-checker state type for the AVST->MFB bridge.
package pcie_avst2mfb_pkg;

  typedef enum logic {CHK_IDLE = 1'b0, CHK_PKT = 1'b1} chk_state_t;

  function automatic int calc_ri(input int region_size, input int block_size);
    return region_size * block_size;
  endfunction

  function automatic int calc_pw(input int ri);
    return (ri > 1) ? $clog2(ri) : 1;
  endfunction

  function automatic int calc_sofw(input int region_size);
    return (region_size > 1) ? $clog2(region_size) : 1;
  endfunction

endpackage

// File: rtl/pcie_avst2mfb_seg_fifox.sv
// First-word-fall-through FIFO; writes into a full FIFO are dropped, contents untouched.
module pcie_avst2mfb_seg_fifox #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ITEMS      = 16,
  parameter string RAM_TYPE   = "AUTO",
  parameter string DEVICE     = "AGILEX",
  localparam int   AW         = (ITEMS > 1) ? $clog2(ITEMS) : 1,
  localparam int   CW         = $clog2(ITEMS + 1)
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_en,
  output logic                  empty,
  output logic [CW-1:0]         status
);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          wr_ok, rd_ok;

  assign full   = (cnt == CW'(ITEMS));
  assign empty  = (cnt == '0);
  assign status = cnt;
  assign wr_ok  = wr_en & ~full;
  assign rd_ok  = rd_en & ~empty;

  // Small buffers go to MLAB on Agilex, larger ones to block RAM; behaviour is identical.
  if (RAM_TYPE == "LUT" || (RAM_TYPE == "AUTO" && DEVICE == "AGILEX" && ITEMS <= 32)) begin : g_lutram
    (* ramstyle = "MLAB, no_rw_check" *) logic [DATA_WIDTH-1:0] mem [ITEMS];
    always_ff @(posedge clk) if (wr_ok) mem[wr_ptr] <= wr_data;
    assign rd_data = mem[rd_ptr];
  end else begin : g_blkram
    (* ramstyle = "M20K, no_rw_check" *) logic [DATA_WIDTH-1:0] mem [ITEMS];
    always_ff @(posedge clk) if (wr_ok) mem[wr_ptr] <= wr_data;
    assign rd_data = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == AW'(ITEMS - 1)) ? '0 : wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= (rd_ptr == AW'(ITEMS - 1)) ? '0 : rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/pcie_avst2mfb_seg.sv
// Segmented AVST -> MFB bridge: input register, FWFT buffer, READY from free space, sticky status.
module pcie_avst2mfb_seg
  import pcie_avst2mfb_pkg::*;
#(
  parameter int    SEGMENTS      = 2,
  parameter int    REGION_SIZE   = 2,
  parameter int    BLOCK_SIZE    = 8,
  parameter int    ITEM_WIDTH    = 32,
  parameter int    META_WIDTH    = 8,
  parameter int    READY_LATENCY = 3,
  parameter int    FIFO_DEPTH    = 16,
  parameter string FIFO_RAM_TYPE = "AUTO",
  parameter string DEVICE        = "AGILEX",
  localparam int   RI = calc_ri(REGION_SIZE, BLOCK_SIZE),
  localparam int   PW = calc_pw(RI),
  localparam int   SW = calc_sofw(REGION_SIZE),
  localparam int   DW = SEGMENTS * RI * ITEM_WIDTH,
  localparam int   MW = SEGMENTS * META_WIDTH
)(
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DW-1:0]          RX_AVST_DATA,
  input  logic [MW-1:0]          RX_AVST_META,
  input  logic [SEGMENTS-1:0]    RX_AVST_SOP,
  input  logic [SEGMENTS-1:0]    RX_AVST_EOP,
  input  logic [SEGMENTS*PW-1:0] RX_AVST_EMPTY,
  input  logic [SEGMENTS-1:0]    RX_AVST_VALID,
  output logic                   RX_AVST_READY,
  output logic [DW-1:0]          TX_MFB_DATA,
  output logic [MW-1:0]          TX_MFB_META,
  output logic [SEGMENTS-1:0]    TX_MFB_SOF,
  output logic [SEGMENTS-1:0]    TX_MFB_EOF,
  output logic [SEGMENTS*SW-1:0] TX_MFB_SOF_POS,
  output logic [SEGMENTS*PW-1:0] TX_MFB_EOF_POS,
  output logic                   TX_MFB_SRC_RDY,
  input  logic                   TX_MFB_DST_RDY,
  output logic                   STAT_OVERFLOW,
  output logic                   STAT_PROTO_ERR,
  input  logic                   STAT_CLR
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [MW-1:0]          meta;
    logic [DW-1:0]          data;
    logic [SEGMENTS-1:0]    sof;
    logic [SEGMENTS-1:0]    eof;
    logic [SEGMENTS*PW-1:0] eof_pos;
  } word_t;

  logic [DW-1:0]          in_data;
  logic [MW-1:0]          in_meta;
  logic [SEGMENTS-1:0]    in_sop, in_eop, in_valid;
  logic [SEGMENTS*PW-1:0] in_empty;
  logic                   in_vld;
  word_t                  wr_word, rd_word;
  logic                   fifo_full, fifo_empty, rst_done;
  logic [CW-1:0]          fifo_cnt, free;
  chk_state_t             chk_state, chk_nxt;
  logic                   chk_err;

  always_ff @(posedge CLK) begin
    in_data  <= RX_AVST_DATA;
    in_meta  <= RX_AVST_META;
    in_sop   <= RX_AVST_SOP;
    in_eop   <= RX_AVST_EOP;
    in_empty <= RX_AVST_EMPTY;
    in_valid <= RST ? RX_AVST_VALID : '0;
  end

  assign in_vld = |in_valid;

  assign wr_word.meta = in_meta;
  assign wr_word.data = in_data;
  assign wr_word.sof  = in_sop & in_valid;
  assign wr_word.eof  = in_eop & in_valid;
  for (genvar s = 0; s < SEGMENTS; s++) begin : g_seg
    assign wr_word.eof_pos[s*PW +: PW] = PW'(RI - 1) - in_empty[s*PW +: PW];
  end

  pcie_avst2mfb_seg_fifox #(
    .DATA_WIDTH ($bits(word_t)),
    .ITEMS      (FIFO_DEPTH),
    .RAM_TYPE   (FIFO_RAM_TYPE),
    .DEVICE     (DEVICE)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_data (wr_word),
    .wr_en   (in_vld),
    .full    (fifo_full),
    .rd_data (rd_word),
    .rd_en   (TX_MFB_DST_RDY),
    .empty   (fifo_empty),
    .status  (fifo_cnt)
  );

  // Margin covers the word in the input stage plus everything the source may still send.
  assign free          = CW'(FIFO_DEPTH) - fifo_cnt;
  assign RX_AVST_READY = rst_done & (free >= CW'(READY_LATENCY + 2) + CW'(in_vld));

  assign TX_MFB_SRC_RDY = ~fifo_empty;
  assign TX_MFB_DATA    = rd_word.data;
  assign TX_MFB_META    = rd_word.meta;
  assign TX_MFB_SOF     = rd_word.sof & {SEGMENTS{~fifo_empty}};
  assign TX_MFB_EOF     = rd_word.eof & {SEGMENTS{~fifo_empty}};
  assign TX_MFB_EOF_POS = rd_word.eof_pos;
  assign TX_MFB_SOF_POS = '0;

  // Segments are walked in order so a packet may end and the next start in one beat.
  always_comb begin
    chk_nxt = chk_state;
    chk_err = 1'b0;
    for (int s = 0; s < SEGMENTS; s++) begin
      if (in_valid[s]) begin
        if (in_sop[s]) begin
          if (chk_nxt == CHK_PKT) chk_err = 1'b1;
          chk_nxt = in_eop[s] ? CHK_IDLE : CHK_PKT;
        end else if (in_eop[s]) begin
          if (chk_nxt == CHK_IDLE) chk_err = 1'b1;
          chk_nxt = CHK_IDLE;
        end
      end else if (chk_nxt == CHK_PKT) begin
        chk_err = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      chk_state      <= CHK_IDLE;
      rst_done       <= 1'b0;
      STAT_OVERFLOW  <= 1'b0;
      STAT_PROTO_ERR <= 1'b0;
    end else begin
      rst_done       <= 1'b1;
      if (in_vld) chk_state <= chk_nxt;
      STAT_OVERFLOW  <= (in_vld & fifo_full) | (STAT_OVERFLOW & ~STAT_CLR);
      STAT_PROTO_ERR <= (in_vld & chk_err) | (STAT_PROTO_ERR & ~STAT_CLR);
    end
  end

endmodule

// File: tb/tb_pcie_avst2mfb_seg.sv
// Directed bench for pcie_avst2mfb_seg with default parameters (2 segments, RI=16, PW=4).
module tb_pcie_avst2mfb_seg;

  localparam int DW = 2 * 16 * 32;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic [MW-1:0] rx_meta = '0;
  logic [1:0]    rx_sop = '0, rx_eop = '0, rx_valid = '0;
  logic [7:0]    rx_empty = '0;
  logic          rx_ready;
  logic [DW-1:0] tx_data;
  logic [MW-1:0] tx_meta;
  logic [1:0]    tx_sof, tx_eof, tx_sof_pos;
  logic [7:0]    tx_eof_pos;
  logic          tx_src_rdy;
  logic          tx_dst_rdy = 1'b0;
  logic          stat_ovf, stat_perr;
  logic          stat_clr = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pcie_avst2mfb_seg dut (
    .CLK            (clk),
    .RST            (rst),
    .RX_AVST_DATA   (rx_data),
    .RX_AVST_META   (rx_meta),
    .RX_AVST_SOP    (rx_sop),
    .RX_AVST_EOP    (rx_eop),
    .RX_AVST_EMPTY  (rx_empty),
    .RX_AVST_VALID  (rx_valid),
    .RX_AVST_READY  (rx_ready),
    .TX_MFB_DATA    (tx_data),
    .TX_MFB_META    (tx_meta),
    .TX_MFB_SOF     (tx_sof),
    .TX_MFB_EOF     (tx_eof),
    .TX_MFB_SOF_POS (tx_sof_pos),
    .TX_MFB_EOF_POS (tx_eof_pos),
    .TX_MFB_SRC_RDY (tx_src_rdy),
    .TX_MFB_DST_RDY (tx_dst_rdy),
    .STAT_OVERFLOW  (stat_ovf),
    .STAT_PROTO_ERR (stat_perr),
    .STAT_CLR       (stat_clr)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int seed);
    logic [DW-1:0] d;
    for (int i = 0; i < 32; i++) d[i*32 +: 32] = {seed[15:0], 16'(i)};
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [1:0] v, input logic [1:0] s, input logic [1:0] e,
                          input logic [7:0] emp, input int seed);
    rx_valid = v; rx_sop = s; rx_eop = e; rx_empty = emp;
    rx_data  = mk_data(seed);
    rx_meta  = 16'(seed * 3);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] s, input logic [1:0] e,
                       input logic [7:0] emp, input int seed);
    set_beat(v, s, e, emp, seed);
    tick();
    rx_valid = '0; rx_sop = '0; rx_eop = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0; rx_valid = '0; stat_clr = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    logic [3:0] rh;
    int tx_cnt, rx_cnt;
    logic saw_low;

    // reset state
    tick(); tick();
    chk("rst_ready", rx_ready, 0);
    chk("rst_src_rdy", tx_src_rdy, 0);
    chk("rst_sof_eof", {tx_sof, tx_eof}, 0);
    chk("rst_flags", {stat_ovf, stat_perr}, 0);
    rst = 1'b1;
    tick();
    chk("rst_ready_after", rx_ready, 1);

    // single-beat packet, EMPTY=5, two-cycle latency
    tx_dst_rdy = 1'b1;
    drive(2'b01, 2'b01, 2'b01, 8'h05, 1);
    chk("033_not_early", tx_src_rdy, 0);
    tick();
    chk("033_src_rdy", tx_src_rdy, 1);
    chk("033_sof", tx_sof, 2'b01);
    chk("033_eof", tx_eof, 2'b01);
    chk("033_eof_pos0", tx_eof_pos[3:0], 10);
    chk("033_sof_pos", tx_sof_pos, 0);
    chk("033_data", tx_data, mk_data(1));
    chk("033_meta", tx_meta, 16'd3);
    tick();
    chk("033_popped", tx_src_rdy, 0);

    // end of A and start of B in the same beat
    drive(2'b11, 2'b01, 2'b00, 8'h00, 10);
    drive(2'b11, 2'b10, 2'b01, 8'h00, 11);
    chk("034_b1_sof", tx_sof, 2'b01);
    chk("034_b1_eof", tx_eof, 2'b00);
    tick();
    chk("034_sof", tx_sof, 2'b10);
    chk("034_eof", tx_eof, 2'b01);
    chk("034_eof_pos0", tx_eof_pos[3:0], 15);
    chk("034_data", tx_data, mk_data(11));
    tick();
    chk("034_no_perr", stat_perr, 0);
    drive(2'b11, 2'b00, 2'b10, 8'h30, 12);
    tick();
    chk("034_eof_pos1", tx_eof_pos[7:4], 12);
    tick();
    chk("034_no_perr_end", stat_perr, 0);

    // compliant source, latency 3, sink stalled for 40 cycles
    do_reset();
    rh = '0; tx_cnt = 0; rx_cnt = 0; saw_low = 1'b0;
    for (int cyc = 0; cyc < 400 && rx_cnt < 30; cyc++) begin
      tx_dst_rdy = (cyc >= 40);
      rh = {rh[2:0], rx_ready};
      if (cyc < 40 && !rx_ready) saw_low = 1'b1;
      if (rh[3] && tx_cnt < 30) begin
        set_beat(2'b01, 2'b01, 2'b01, 8'h00, 100 + tx_cnt);
        tx_cnt++;
      end else begin
        rx_valid = '0;
      end
      if (tx_src_rdy && tx_dst_rdy) begin
        chk("035_order", tx_data, mk_data(100 + rx_cnt));
        rx_cnt++;
      end
      tick();
    end
    rx_valid = '0;
    chk("035_count", rx_cnt, 30);
    chk("035_ready_dropped", saw_low, 1);
    chk("035_no_ovf", stat_ovf, 0);

    // source ignores READY: 20 words into a 16-deep buffer
    do_reset();
    tx_dst_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(2'b01, 2'b01, 2'b01, 8'h00, 200 + i);
      if (i == 16) chk("036_ovf_not_yet", stat_ovf, 0);
    end
    tick(); tick();
    chk("036_ovf", stat_ovf, 1);
    rx_cnt = 0;
    tx_dst_rdy = 1'b1;
    for (int cyc = 0; cyc < 40 && tx_src_rdy; cyc++) begin
      chk("036_order", tx_data, mk_data(200 + rx_cnt));
      rx_cnt++;
      tick();
    end
    chk("036_count", rx_cnt, 16);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("036_clr", stat_ovf, 0);

    // two SOPs in one beat
    drive(2'b11, 2'b11, 2'b00, 8'h00, 20);
    chk("037_perr_early", stat_perr, 0);
    tick();
    chk("037_perr", stat_perr, 1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("037_clr", stat_perr, 0);
    drive(2'b11, 2'b01, 2'b00, 8'h00, 21);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("037_evt_wins", stat_perr, 1);

    // reset mid-packet with 5 words buffered
    do_reset();
    tx_dst_rdy = 1'b0;
    drive(2'b11, 2'b01, 2'b00, 8'h00, 300);
    for (int i = 1; i < 5; i++) drive(2'b11, 2'b00, 2'b00, 8'h00, 300 + i);
    tick(); tick();
    chk("038_buffered", tx_src_rdy, 1);
    rst = 1'b0;
    tick();
    chk("038_rst_src_rdy", tx_src_rdy, 0);
    chk("038_rst_ready", rx_ready, 0);
    chk("038_rst_sof", tx_sof, 0);
    rst = 1'b1;
    tick();
    chk("038_ready_after", rx_ready, 1);
    chk("038_empty_after", tx_src_rdy, 0);
    drive(2'b11, 2'b01, 2'b00, 8'h00, 400);
    tick(); tick();
    chk("038_no_perr", stat_perr, 0);
    chk("038_new_word", tx_src_rdy, 1);
    chk("038_new_sof", tx_sof, 2'b01);
    chk("038_new_data", tx_data, mk_data(400));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
